// File: rtl/frame_sequencer_if.sv
// Bundle between the UART byte receiver, the frame sequencer and the tester back-end.
// The master modport is the sequencer side. The slave modport is the environment side.
interface frame_sequencer_if;
    // RX_VALID is a one-cycle strobe and has no back-pressure.
    // The back-end takes a command on any cycle where CMD_VALID and CMD_READY are both high.
    // CMD_VALID, CMD_OP, CMD_VEC and CMD_TAG do not change until that cycle.
    // After a command is raised, CMD_VALID stays high until it is accepted.
    logic         RX_VALID;
    logic [7:0]   RX_DATA;
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [1:0]   CMD_OP;
    logic [125:0] CMD_VEC;
    logic [1:0]   CMD_TAG;
    logic         BUSY;
    logic         ERR_TIMEOUT;
    logic         ERR_OPCODE;
    logic         ERR_OVERRUN;
    logic [2:0]   DBG_STATE;

    modport master (
        input  RX_VALID, RX_DATA, CMD_READY,
        output CMD_VALID, CMD_OP, CMD_VEC, CMD_TAG, BUSY,
        output ERR_TIMEOUT, ERR_OPCODE, ERR_OVERRUN, DBG_STATE
    );

    modport slave (
        output RX_VALID, RX_DATA, CMD_READY,
        input  CMD_VALID, CMD_OP, CMD_VEC, CMD_TAG, BUSY,
        input  ERR_TIMEOUT, ERR_OPCODE, ERR_OVERRUN, DBG_STATE
    );
endinterface

// File: rtl/frame_sequencer.sv
// Builds 16-byte host frames from the UART byte stream and decodes LOAD/RUN/READ.
// It then issues one command to the back-end for each valid frame.
module frame_sequencer #(
    parameter int FRAME_BYTES      = 16,
    parameter int BYTE_TIMEOUT     = 173600,
    parameter int VEC_WAIT_TIMEOUT = 1000000
) (
    input  logic              CLK,
    input  logic              RST_BAR,
    frame_sequencer_if.master bus
);

    localparam int TMAX = (BYTE_TIMEOUT > VEC_WAIT_TIMEOUT) ? BYTE_TIMEOUT : VEC_WAIT_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_TIMEOUT - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(VEC_WAIT_TIMEOUT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'(FRAME_BYTES - 1);

    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR      = 3'd1;
    localparam logic [2:0] S_WAIT_VEC = 3'd2;
    localparam logic [2:0] S_VEC      = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;

    logic [2:0]    state;
    logic [3:0]    byte_cnt;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_limit;
    logic [1:0]    op_q;
    logic          drop;
    logic [119:0]  asm_q;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [125:0]  cmd_vec;
    logic [1:0]    cmd_tag;
    logic          busy;
    logic          err_timeout;
    logic          err_opcode;
    logic          err_overrun;

    // The gap before the first vector byte can be much longer than the gap between bytes in a frame.
    always_comb begin
        idle_limit = BYTE_LAST;
        if (state == S_WAIT_VEC) idle_limit = WAIT_LAST;
    end

    always_ff @(posedge CLK) begin
        if (!RST_BAR) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            op_q        <= '0;
            drop        <= 1'b0;
            asm_q       <= '0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_vec     <= '0;
            cmd_tag     <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    idle_cnt <= '0;
                    if (bus.RX_VALID) begin
                        state    <= S_HDR;
                        busy     <= 1'b1;
                        byte_cnt <= 4'd1;
                        drop     <= 1'b0;
                        case (bus.RX_DATA)
                            8'h03:   op_q <= OP_LOAD;
                            8'h05:   op_q <= OP_RUN;
                            8'h06:   op_q <= OP_READ;
                            default: begin
                                // Consume the rest of the frame so that the next frame stays aligned.
                                drop       <= 1'b1;
                                err_opcode <= 1'b1;
                            end
                        endcase
                    end
                end

                S_HDR, S_WAIT_VEC, S_VEC: begin
                    if (!bus.RX_VALID) begin
                        if (idle_cnt == idle_limit) begin
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                            idle_cnt    <= '0;
                            err_timeout <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                        if (state == S_HDR) begin
                            byte_cnt <= byte_cnt + 4'd1;
                            if (byte_cnt == LAST_BYTE) begin
                                if (drop) begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end else if (op_q == OP_LOAD) begin
                                    state <= S_WAIT_VEC;
                                end else begin
                                    state     <= S_ISSUE;
                                    cmd_valid <= 1'b1;
                                    cmd_op    <= op_q;
                                end
                            end
                        end else if (state == S_WAIT_VEC) begin
                            asm_q[7:0] <= bus.RX_DATA;
                            byte_cnt   <= 4'd1;
                            state      <= S_VEC;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                            for (int k = 1; k < 15; k++) begin
                                if (byte_cnt == 4'(k)) asm_q[8*k +: 8] <= bus.RX_DATA;
                            end
                            // The last byte goes straight to the outputs, so a partial frame never reaches them.
                            if (byte_cnt == LAST_BYTE) begin
                                cmd_vec   <= {bus.RX_DATA[5:0], asm_q};
                                cmd_tag   <= bus.RX_DATA[7:6];
                                cmd_op    <= OP_LOAD;
                                cmd_valid <= 1'b1;
                                state     <= S_ISSUE;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    idle_cnt <= '0;
                    if (bus.RX_VALID) err_overrun <= 1'b1;
                    if (bus.CMD_READY) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CMD_VALID   = cmd_valid;
    assign bus.CMD_OP      = cmd_op;
    assign bus.CMD_VEC     = cmd_vec;
    assign bus.CMD_TAG     = cmd_tag;
    assign bus.BUSY        = busy;
    assign bus.ERR_TIMEOUT = err_timeout;
    assign bus.ERR_OPCODE  = err_opcode;
    assign bus.ERR_OVERRUN = err_overrun;
    assign bus.DBG_STATE   = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer. It uses shortened timeouts.
// A negedge monitor compares accepted commands and error pulses against queues of expected events that include the cycle.
module tb_frame_sequencer;
    localparam int BT  = 40;
    localparam int VWT = 70;

    logic clk = 1'b0;
    logic rst_bar = 1'b0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    int   last_stall = -1;
    logic [127:0] model_vec = '0;
    logic [3:0]   snap_optag;
    logic [125:0] snap_vec;

    // Command entry: {cycle[31:0], op[1:0], tag[1:0], vec[125:0]}. Error entry: {kind[1:0], cycle[31:0]}.
    logic [161:0] exp_cmd_q[$];
    logic [33:0]  exp_err_q[$];

    frame_sequencer_if bus();

    frame_sequencer #(
        .FRAME_BYTES(16),
        .BYTE_TIMEOUT(BT),
        .VEC_WAIT_TIMEOUT(VWT)
    ) dut (
        .CLK(clk),
        .RST_BAR(rst_bar),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        last_cyc     = cyc;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        @(posedge clk);
        #1;
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] fill);
        send_byte(op);
        for (int k = 1; k < 16; k++) begin
            idle(1);
            send_byte(fill);
        end
    endtask

    task automatic send_vec(input logic [127:0] v, input int n, input int g0, input int g5);
        for (int k = 0; k < n; k++) begin
            idle((k == 0) ? g0 : ((k == 5) ? g5 : 1));
            send_byte(v[8*k +: 8]);
        end
    endtask

    task automatic push_cmd(input int at, input logic [1:0] op);
        exp_cmd_q.push_back({32'(at), op, model_vec[127:126], model_vec[125:0]});
    endtask

    task automatic push_err(input logic [1:0] kind, input int at);
        exp_err_q.push_back({kind, 32'(at)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, 128'(bus.CMD_VALID), 128'd0);
        check({tag, "_cmd_op"}, 128'(bus.CMD_OP), 128'd0);
        check({tag, "_cmd_vec"}, 128'(bus.CMD_VEC), 128'd0);
        check({tag, "_cmd_tag"}, 128'(bus.CMD_TAG), 128'd0);
        check({tag, "_busy"}, 128'(bus.BUSY), 128'd0);
        check({tag, "_err_timeout"}, 128'(bus.ERR_TIMEOUT), 128'd0);
        check({tag, "_err_opcode"}, 128'(bus.ERR_OPCODE), 128'd0);
        check({tag, "_err_overrun"}, 128'(bus.ERR_OVERRUN), 128'd0);
    endtask

    task automatic take_err(input logic [1:0] kind);
        logic [33:0] e;
        if (exp_err_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_err: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_err_q.pop_front();
            check("err_kind", 128'(kind), 128'(e[33:32]));
            check("err_cycle", 128'(cyc), 128'(e[31:0]));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [161:0] e;
        if (rst_bar) begin
            if (bus.ERR_TIMEOUT === 1'b1) take_err(2'd1);
            if (bus.ERR_OPCODE === 1'b1)  take_err(2'd2);
            if (bus.ERR_OVERRUN === 1'b1) take_err(2'd3);
            if (bus.CMD_VALID === 1'b1) begin
                if (stall_cnt > 0) begin
                    check("hold_op_tag", 128'({bus.CMD_OP, bus.CMD_TAG}), 128'(snap_optag));
                    check("hold_vec", 128'(bus.CMD_VEC), 128'(snap_vec));
                end
                if (bus.CMD_READY === 1'b1) begin
                    if (exp_cmd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_cmd: got op %0d at cycle %0d, expected none", bus.CMD_OP, cyc);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd_cycle", 128'(cyc), 128'(e[161:130]));
                        check("cmd_op", 128'(bus.CMD_OP), 128'(e[129:128]));
                        check("cmd_tag", 128'(bus.CMD_TAG), 128'(e[127:126]));
                        check("cmd_vec", 128'(bus.CMD_VEC), 128'(e[125:0]));
                    end
                    last_stall = stall_cnt;
                    stall_cnt  = 0;
                end else begin
                    stall_cnt++;
                end
                snap_optag = {bus.CMD_OP, bus.CMD_TAG};
                snap_vec   = bus.CMD_VEC;
            end else begin
                stall_cnt = 0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got cycle budget exhausted, expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [127:0] v;
        int c;

        bus.RX_VALID  = 1'b0;
        bus.RX_DATA   = 8'h00;
        bus.CMD_READY = 1'b0;
        rst_bar       = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        rst_bar = 1'b1;
        idle(2);

        // LOAD with the back-end always ready
        bus.CMD_READY = 1'b1;
        send_hdr(8'h03, 8'hFF);
        check("busy_wait_vec", 128'(bus.BUSY), 128'd1);
        v = '0;
        for (int k = 0; k < 15; k++) v[8*k +: 8] = 8'(k);
        v[127:120] = 8'hC0;
        send_vec(v, 16, 1, 1);
        model_vec = v;
        push_cmd(last_cyc + 1, 2'd1);
        check("load_valid_rise", 128'(bus.CMD_VALID), 128'd1);
        check("load_vec_b1", 128'(bus.CMD_VEC[15:8]), 128'h01);
        idle(1);
        check("load_valid_fall", 128'(bus.CMD_VALID), 128'd0);
        check("load_busy_fall", 128'(bus.BUSY), 128'd0);

        // RUN held for 50 cycles, overrun mid-stall and on the accept cycle
        bus.CMD_READY = 1'b0;
        send_hdr(8'h05, 8'h00);
        c = last_cyc;
        idle(4);
        send_byte(8'hAA);
        push_err(2'd3, last_cyc + 1);
        idle(45);
        check("run_stall_cycle", 128'(cyc), 128'(c + 51));
        push_cmd(cyc, 2'd2);
        push_err(2'd3, cyc + 1);
        bus.CMD_READY = 1'b1;
        send_byte(8'h55);
        check("run_stall_len", 128'(last_stall), 128'd50);
        check("run_valid_fall", 128'(bus.CMD_VALID), 128'd0);

        // bad opcode, then READ
        push_err(2'd2, cyc + 1);
        send_hdr(8'h07, 8'h5A);
        check("bad_busy_idle", 128'(bus.BUSY), 128'd0);
        check("bad_no_valid", 128'(bus.CMD_VALID), 128'd0);
        send_hdr(8'h06, 8'h00);
        push_cmd(last_cyc + 1, 2'd3);
        idle(3);

        // timeout after 8 vector bytes
        send_hdr(8'h03, 8'h11);
        v = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        send_vec(v, 8, 1, 1);
        push_err(2'd1, last_cyc + BT + 1);
        idle(BT + 5);
        check("vec_to_keep_vec", 128'(bus.CMD_VEC), 128'(model_vec[125:0]));
        check("vec_to_keep_tag", 128'(bus.CMD_TAG), 128'(model_vec[127:126]));
        check("vec_to_busy", 128'(bus.BUSY), 128'd0);

        // no vector after the LOAD header
        send_hdr(8'h03, 8'h22);
        push_err(2'd1, last_cyc + VWT + 1);
        idle(VWT + 5);
        check("wait_to_busy", 128'(bus.BUSY), 128'd0);

        // a byte arriving on the expiry cycle is taken, both in WAIT_VEC and in VEC
        send_hdr(8'h03, 8'h33);
        for (int k = 0; k < 15; k++) v[8*k +: 8] = 8'(8'h10 + k);
        v[127:120] = 8'h47;
        send_vec(v, 16, VWT - 1, BT - 1);
        model_vec = v;
        push_cmd(last_cyc + 1, 2'd1);
        idle(3);

        // reset during vector byte 10
        send_hdr(8'h03, 8'h44);
        send_vec(128'hFFEEDDCC_BBAA9988_77665544_33221100, 10, 1, 1);
        idle(1);
        rst_bar = 1'b0;
        send_byte(8'h99);
        check_reset_outputs("rst_vec");
        rst_bar = 1'b1;
        model_vec = '0;
        idle(2);

        // reset while a command is pending, then a fresh RUN
        bus.CMD_READY = 1'b0;
        send_hdr(8'h05, 8'h55);
        idle(3);
        rst_bar = 1'b0;
        idle(1);
        check_reset_outputs("rst_issue");
        rst_bar = 1'b1;
        bus.CMD_READY = 1'b1;
        idle(2);
        send_hdr(8'h05, 8'h66);
        push_cmd(last_cyc + 1, 2'd2);

        idle(5);
        check("cmd_q_empty", 128'(exp_cmd_q.size()), 128'd0);
        check("err_q_empty", 128'(exp_err_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
